// File: rtl/lab2_dec2bin_entry.sv
// Decimal-to-binary entry block for the DE1-SoC.
// Two BCD digits (tens, then ones) are keyed on SW[3:0] and committed with
// KEY[1]. Accepted digits are echoed on HEX1/HEX0. The binary value 0..99 and
// the done/error flags appear on LEDR. KEY[0] is an asynchronous active-low reset.
module lab2_dec2bin_entry (
    input  logic       CLOCK_50,
    input  logic [1:0] KEY,
    input  logic [9:0] SW,
    output logic [9:0] LEDR,
    output logic [0:6] HEX1,
    output logic [0:6] HEX0
);

    typedef enum logic [1:0] {
        WAIT_TENS = 2'd0,
        WAIT_ONES = 2'd1,
        DONE      = 2'd2
    } state_e;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    logic       rst_n;
    logic [3:0] digit;
    logic       digit_ok;
    logic       press;

    logic       s1_q, s2_q, prev_q;
    state_e     state_q, state_d;
    logic [3:0] tens_q, tens_d;
    logic [3:0] ones_q, ones_d;
    logic [6:0] value_q, value_d;
    logic       err_q, err_d;
    logic [6:0] tens_x, ones_x;

    assign rst_n    = KEY[0];
    assign digit    = SW[3:0];
    assign digit_ok = (digit <= 4'd9);

    // Active-low segment patterns, abcdefg with a in the MSB.
    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'b0000001;
            4'd1:    seg7 = 7'b1001111;
            4'd2:    seg7 = 7'b0010010;
            4'd3:    seg7 = 7'b0000110;
            4'd4:    seg7 = 7'b1001100;
            4'd5:    seg7 = 7'b0100100;
            4'd6:    seg7 = 7'b0100000;
            4'd7:    seg7 = 7'b0001111;
            4'd8:    seg7 = 7'b0000000;
            4'd9:    seg7 = 7'b0000100;
            default: seg7 = SEG_BLANK;
        endcase
    endfunction

    // Synchronize the enter button and keep one cycle of history for edge detect.
    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge value of its source; blocking here would collapse the chain.
    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            s1_q   <= 1'b0;
            s2_q   <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            s1_q   <= ~KEY[1];
            s2_q   <= s1_q;
            prev_q <= s2_q;
        end
    end

    // One-cycle pulse on the rising edge of the synchronized (inverted) button.
    assign press = s2_q & ~prev_q;

    // tens*10 + ones as (tens<<3) + (tens<<1) + ones; 99 fits in 7 bits.
    assign tens_x = {3'b000, tens_q};
    assign ones_x = {3'b000, digit};

    // Next-state and datapath update; all registers hold unless a press arrives.
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        tens_d  = tens_q;
        ones_d  = ones_q;
        value_d = value_q;
        err_d   = err_q;
        if (press) begin
            case (state_q)
                WAIT_ONES: begin
                    if (digit_ok) begin
                        ones_d  = digit;
                        value_d = (tens_x << 3) + (tens_x << 1) + ones_x;
                        err_d   = 1'b0;
                        state_d = DONE;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                // WAIT_TENS and DONE accept a new tens digit identically;
                // an invalid digit leaves the state where it is.
                default: begin
                    if (digit_ok) begin
                        tens_d  = digit;
                        err_d   = 1'b0;
                        state_d = WAIT_ONES;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            endcase
        end
    end

    // FSM state and entry registers; reset discards any partial entry.
    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= WAIT_TENS;
            tens_q  <= 4'd0;
            ones_q  <= 4'd0;
            value_q <= 7'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tens_q  <= tens_d;
            ones_q  <= ones_d;
            value_q <= value_d;
            err_q   <= err_d;
        end
    end

    // Outputs decode registers only, so SW never reaches them combinationally.
    always_comb begin
        LEDR = {err_q, (state_q == DONE), 1'b0, value_q};
        HEX1 = (state_q == WAIT_TENS) ? SEG_BLANK : seg7(tens_q);
        HEX0 = (state_q == DONE)      ? seg7(ones_q) : SEG_BLANK;
    end

endmodule

// File: doc/lab2_dec2bin_entry.md
# lab2_dec2bin_entry

Sequential decimal-to-binary entry block for the DE1-SoC lab set, the inverse of the binary-to-decimal display path. The user keys two BCD digits, tens then ones, on SW[3:0] and commits each one with pushbutton KEY[1]. The block validates each digit, echoes the accepted digits on HEX1/HEX0, and drives the 7-bit binary value (0–99) and status flags on LEDR. It is a standalone top level driven from CLOCK_50.

## Interface
- No parameters; all widths fixed.
- CLOCK_50  input  1  50 MHz system clock; all state on rising edge.
- KEY  input  2  pushbuttons, active-low, asynchronous to CLOCK_50.
  - KEY[0] is the reset: asynchronous, active-low.
  - KEY[1] is the digit-enter button.
- SW  input  10  SW[3:0] is the BCD digit being entered. SW[9:4] are ignored.
- LEDR  output  10  status and result:
  - LEDR[6:0] binary value.
  - LEDR[7] = 0.
  - LEDR[8] done.
  - LEDR[9] digit error.
- HEX1  output  [0:6]  tens-digit echo, active-low segments, seg 0 = a … seg 6 = g.
- HEX0  output  [0:6]  ones-digit echo, same encoding.

## Operation
- **Press detection**
  - Two-flop synchronizer on ~KEY[1] (s1, s2), plus a history flop prev.
  - press = s2 & ~prev. It is one cycle wide per physical press, however long the button is held.
  - No debounce inside the block.
- **FSM states:** WAIT_TENS, WAIT_ONES, DONE.
  - WAIT_TENS, on press:
    - SW[3:0] ≤ 9: tens ← SW[3:0], err ← 0, go to WAIT_ONES.
    - Otherwise: err ← 1, stay in WAIT_TENS, tens unchanged.
  - WAIT_ONES, on press:
    - SW[3:0] ≤ 9: ones ← SW[3:0], value ← tens·10 + ones, err ← 0, go to DONE.
    - Otherwise: err ← 1, stay in WAIT_ONES.
  - DONE, on press: behaves exactly as WAIT_TENS. A valid digit becomes the new tens and the FSM goes to WAIT_ONES. An invalid digit sets err and the FSM stays in DONE.
  - With no press, the state and all registers hold.
- **Arithmetic**
  - value = (tens<<3) + (tens<<1) + ones, computed 7 bits wide. The maximum is 99 = 7'b1100011, so no overflow is possible.
  - The value register updates only on the WAIT_ONES→DONE transition. The previous result stays on LEDR[6:0] while a new entry is in progress.
- **Outputs**
  - LEDR[8] = (state == DONE).
  - LEDR[9] = err. err is sticky until the next valid press or reset.
  - HEX1 shows tens in WAIT_ONES and DONE, and is blank (7'b1111111) in WAIT_TENS.
  - HEX0 shows ones in DONE, and is blank otherwise.
  - Decimal 7-seg patterns, active-low, abcdefg order:
    - 0 = 0000001, 1 = 1001111, 2 = 0010010, 3 = 0000110, 4 = 1001100
    - 5 = 0100100, 6 = 0100000, 7 = 0001111, 8 = 0000000, 9 = 0000100
  - All outputs are registered or decoded from registers only. There is no combinational path from SW to any output.
- **Reset (KEY[0] low)**, effective immediately and independent of the clock:
  - state = WAIT_TENS.
  - tens = ones = value = 0, err = 0.
  - s1 = s2 = prev = 0.
  - Resulting outputs: LEDR = 10'b0, HEX1 = HEX0 = 7'b1111111.
  - Reset asserted mid-entry discards any captured tens digit.
  - After KEY[0] is released, a KEY[1] already held low produces exactly one press.

## Timing
- KEY[1] first sampled low at edge N:
  - press is high during cycle N+1→N+2.
  - FSM, digit registers and outputs update at edge N+2, i.e. two-cycle latency from first sample to visible output.
- SW[3:0] is sampled in the same cycle press is high. It must be stable from edge N+1 through edge N+2.
- KEY[1] must be released (high) for at least 2 cycles before the next press is recognized.
- A simultaneous KEY[0] reset and press: reset wins.

## Test plan
- Reset with KEY[1] idle → LEDR = 0, HEX1 = HEX0 = 1111111, state WAIT_TENS.
- Press with SW=4, then press with SW=2 → after the second press:
  - LEDR[6:0] = 0101010 (42), LEDR[8] = 1.
  - HEX1 = 1001100, HEX0 = 0010010.
  - Each update lands exactly 2 cycles after KEY[1] is first sampled low.
- Press with SW=12 in WAIT_TENS → LEDR[9] = 1, HEX1 stays blank. Then press with SW=9 → LEDR[9] = 0, HEX1 = 0000100. Then press with SW=9 → LEDR[6:0] = 1100011 (99).
- In DONE with value 42, press with SW=7 → state WAIT_ONES, LEDR[8] = 0, LEDR[6:0] still 42, HEX1 = 0001111, HEX0 blank. Then press with SW=0 → LEDR[6:0] = 70 (1000110).
- Hold KEY[1] low for 100 cycles with SW=3 → exactly one capture, state WAIT_ONES. Then assert KEY[0] mid-entry → all outputs return to reset values immediately, without waiting for a clock edge.
